operand_issuer: RTL

Transmitting end of the operand-load interface: buffers operand pairs from the control path and drives `tx`/`in1`/`in2` toward the operand memory stage. Every pair goes out as two consecutive `tx = LOAD` cycles, so the memory stage's 1-bit alternation counter latches `in1` then `in2`. Also issues `CLEAR`, and keeps a 6-phase counter in lock-step with the memory stage's phase sequence.

---
 rtl/cpu_pkg.sv | 35 +++
 rtl/pair_fifo.sv | 83 ++++++++
 rtl/operand_issuer.sv | 127 ++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Command encodings, phase count and issuer FSM states shared by the
// operand issuer and the operand memory stage.
package cpu_pkg;

  localparam logic [3:0] CLEAR = 4'd0;
  localparam logic [3:0] LOAD  = 4'd1;
  localparam logic [3:0] HOLD  = 4'd2;

  localparam int unsigned PHASE_COUNT = 6;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD_A = 2'd1,
    ST_LOAD_B = 2'd2,
    ST_CLR    = 2'd3
  } issue_state_e;

  function automatic logic [3:0] phase_advance(input logic [3:0] phase);
    if (phase == 4'(PHASE_COUNT - 1)) begin
      return 4'd0;
    end else begin
      return phase + 4'd1;
    end
  endfunction

  function automatic logic [3:0] state_cmd(input issue_state_e st);
    case (st)
      ST_LOAD_A: return LOAD;
      ST_LOAD_B: return LOAD;
      ST_CLR:    return CLEAR;
      default:   return HOLD;
    endcase
  endfunction

endpackage

// File: rtl/pair_fifo.sv
// Operand-pair FIFO with registered full/empty and a synchronous flush.
// Flush takes priority over a push in the same cycle.
module pair_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [2*WIDTH-1:0]       wdata,
  output logic [2*WIDTH-1:0]       rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [2*WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]      wr_ptr_r;
  logic [AW-1:0]      rd_ptr_r;
  logic [AW:0]        count_r;
  logic [AW:0]        count_next_s;
  logic               full_r;
  logic               empty_r;
  logic               push_ok_s;
  logic               pop_ok_s;

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign pop_ok_s  = pop && !empty_r;
  assign push_ok_s = push && (!full_r || pop_ok_s);

  // Next occupancy from flush, push and pop.
  always_comb begin
    count_next_s = count_r;
    if (flush) begin
      count_next_s = (AW+1)'(0);
    end else begin
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_next_s = count_r + (AW+1)'(1);
        2'b01:   count_next_s = count_r - (AW+1)'(1);
        default: count_next_s = count_r;
      endcase
    end
  end

  // Pointers, occupancy and status flags.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      wr_ptr_r <= AW'(0);
      rd_ptr_r <= AW'(0);
      count_r  <= (AW+1)'(0);
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
    end else begin
      if (flush) begin
        wr_ptr_r <= AW'(0);
        rd_ptr_r <= AW'(0);
      end else begin
        if (push_ok_s) wr_ptr_r <= wr_ptr_r + AW'(1);
        if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      count_r <= count_next_s;
      full_r  <= (count_next_s == (AW+1)'(DEPTH));
      empty_r <= (count_next_s == (AW+1)'(0));
    end
  end

  // Storage array.
  always_ff @(posedge clock) begin
    if (push_ok_s && !flush) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  assign rdata = mem_r[rd_ptr_r];
  assign full  = full_r;
  assign empty = empty_r;
  assign count = count_r;

endmodule

// File: rtl/operand_issuer.sv
// Issues buffered operand pairs as two LOAD cycles on phases 0 and 1,
// plus CLEAR commands, in lock-step with the memory stage's 6-phase counter.
module operand_issuer
  import cpu_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_a,
  input  logic [WIDTH-1:0] push_b,
  input  logic             clear_req,
  output logic             full,
  output logic             empty,
  output logic             drop,
  output logic [3:0]       tx,
  output logic [WIDTH-1:0] in1,
  output logic [WIDTH-1:0] in2,
  output logic [3:0]       phase,
  output logic             busy
);

  localparam int CW = $clog2(DEPTH) + 1;

  issue_state_e       state_r;
  issue_state_e       state_next_s;
  logic [3:0]         phase_r;
  logic               pend_r;
  logic               pend_next_s;
  logic               flush_s;
  logic               pop_s;
  logic               drop_s;
  logic [3:0]         tx_r;
  logic [WIDTH-1:0]   in1_r;
  logic [WIDTH-1:0]   in2_r;
  logic               drop_r;
  logic               busy_r;
  logic [2*WIDTH-1:0] head_s;
  logic [CW-1:0]      count_s;

  pair_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clock  (clock),
    .resetn (resetn),
    .push   (push),
    .pop    (pop_s),
    .flush  (flush_s),
    .wdata  ({push_a, push_b}),
    .rdata  (head_s),
    .full   (full),
    .empty  (empty),
    .count  (count_s)
  );

  // Next-state, FIFO control and reject detection. Clears arriving mid-pair
  // are parked in pend_r so a pair is never split.
  always_comb begin
    state_next_s = state_r;
    pend_next_s  = pend_r;
    flush_s      = 1'b0;
    pop_s        = 1'b0;
    drop_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (clear_req || pend_r) begin
          state_next_s = ST_CLR;
          flush_s      = 1'b1;
          pend_next_s  = 1'b0;
        end else if (!empty && (phase_r == 4'(PHASE_COUNT - 1))) begin
          state_next_s = ST_LOAD_A;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_LOAD_A: begin
        state_next_s = ST_LOAD_B;
        pend_next_s  = pend_r | clear_req;
      end
      ST_LOAD_B: begin
        pop_s        = 1'b1;
        state_next_s = ST_IDLE;
        pend_next_s  = pend_r | clear_req;
      end
      ST_CLR: begin
        state_next_s = ST_IDLE;
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
    drop_s = push && (count_s == CW'(DEPTH)) && !pop_s && !flush_s;
  end

  // State, phase counter and registered outputs driven from the next state.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_r <= ST_IDLE;
      phase_r <= 4'd0;
      pend_r  <= 1'b0;
      tx_r    <= HOLD;
      in1_r   <= WIDTH'(0);
      in2_r   <= WIDTH'(0);
      drop_r  <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      phase_r <= phase_advance(phase_r);
      pend_r  <= pend_next_s;
      tx_r    <= state_cmd(state_next_s);
      drop_r  <= drop_s;
      busy_r  <= (state_next_s != ST_IDLE);
      if ((state_next_s == ST_LOAD_A) || (state_next_s == ST_LOAD_B)) begin
        in1_r <= head_s[2*WIDTH-1:WIDTH];
        in2_r <= head_s[WIDTH-1:0];
      end
    end
  end

  assign tx    = tx_r;
  assign in1   = in1_r;
  assign in2   = in2_r;
  assign phase = phase_r;
  assign drop  = drop_r;
  assign busy  = busy_r;

endmodule
